// File: rtl/dn_route_loader.sv
// rtl/dn_route_loader.sv - Benes network route loader: assembles packed config words into a shadow, commits atomically.
// Words fill 2-bit switch slots LSB-first; a full, correctly framed load is committed, pulsed on set_en and held on route_en.
module dn_route_loader #(
    parameter int N        = 64,
    parameter int N_LEVELS = 2 * $clog2(N) - 1,
    parameter int CW       = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    cfg_valid_i,
    output logic                    cfg_ready_o,
    input  logic [CW-1:0]           cfg_data_i,
    input  logic                    cfg_last_i,
    input  logic                    release_i,
    output logic [N_LEVELS*N-1:0]   route_signals_o,
    output logic                    set_en_o,
    output logic                    route_en_o,
    output logic                    busy_o,
    output logic                    cfg_err_o
);

    localparam int NUM_SW = N_LEVELS * N / 2;
    localparam int SPW    = CW / 2;
    localparam int NW     = (NUM_SW + SPW - 1) / SPW;
    localparam int WCW    = $clog2(NW + 1);
    localparam int SHW    = NW * CW;
    localparam int RW     = 2 * NUM_SW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SET,
        S_ACTIVE
    } state_t;

    state_t           state_q;
    logic [WCW-1:0]   wcnt_q;
    logic [SHW-1:0]   shadow_q;
    logic [SHW-1:0]   shadow_d;
    logic [RW-1:0]    route_q;
    logic             set_en_q;
    logic             route_en_q;
    logic             busy_q;
    logic             err_q;
    logic             accept;
    logic             final_word;

    assign cfg_ready_o     = ~reset_i & ((state_q == S_IDLE) || (state_q == S_LOAD));
    assign accept          = cfg_valid_i & cfg_ready_o;
    assign final_word      = (wcnt_q == WCW'(NW - 1));
    assign route_signals_o = route_q;
    assign set_en_o        = set_en_q;
    assign route_en_o      = route_en_q;
    assign busy_o          = busy_q;
    assign cfg_err_o       = err_q;

    // Shadow view including the beat being accepted, so the commit can copy it on the same edge.
    always_comb begin
        shadow_d = shadow_q;
        for (int k = 0; k < NW; k++) begin
            if (accept && (wcnt_q == WCW'(k))) begin
                shadow_d[k*CW +: CW] = cfg_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            shadow_q   <= '0;
            route_q    <= '0;
            set_en_q   <= 1'b0;
            route_en_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            set_en_q <= 1'b0;
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (accept) begin
                        if (final_word && cfg_last_i) begin
                            route_q  <= shadow_d[RW-1:0];
                            wcnt_q   <= '0;
                            state_q  <= S_SET;
                            set_en_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end else if (final_word || cfg_last_i) begin
                            // Misframed load: abandon it, committed routes stay untouched.
                            err_q   <= 1'b1;
                            wcnt_q  <= '0;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            wcnt_q  <= wcnt_q + WCW'(1);
                            state_q <= S_LOAD;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_SET: begin
                    state_q    <= S_ACTIVE;
                    route_en_q <= 1'b1;
                end
                S_ACTIVE: begin
                    if (release_i) begin
                        state_q    <= S_IDLE;
                        route_en_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
